// File: rtl/dmem_pkg.sv
// Shared types and constants for the byte-serial Y86-64 data memory.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } dmem_state_e;

  localparam int BYTES_PER_WORD = 8;
  localparam int LANE_W         = 8;

endpackage

// File: rtl/byte_ram.sv
// Byte-wide RAM: one synchronous write port (blocked while rst_n is low) and
// one asynchronous read port sharing a single address.
module byte_ram
  import dmem_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  localparam int AW = $clog2(MEM_BYTES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [LANE_W-1:0] wdata,
  output logic [LANE_W-1:0] rdata
);

  logic [LANE_W-1:0] mem [MEM_BYTES];

  // Contents survive reset; only the write strobe is suppressed.
  always_ff @(posedge clk) begin
    if (rst_n && we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_memory.sv
// Y86-64 data memory: each 64-bit access runs as eight little-endian byte cycles
// on byte_ram. Define DMEM_ALIGN_CHECK_EN to reject addresses with addr[2:0]!=0.
module data_memory
  import dmem_pkg::*;
#(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        readEn,
  input  logic        writeEn,
  input  logic [63:0] mem_addr,
  input  logic [63:0] mem_data,
  output logic [63:0] valM,
  output logic        dm_error,
  output logic        busy,
  output logic        done
);

  localparam int AW = $clog2(MEM_BYTES);
  localparam logic [63:0] LAST_START = 64'(MEM_BYTES - BYTES_PER_WORD);

  dmem_state_e       state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              op_rd_q, op_rd_d;
  logic              err_q, err_d;
  logic [63:0]       valm_q, valm_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [63:0]       data_q, data_d;

  logic              req;
  logic              misalign;
  logic              acc_err;
  logic [AW-1:0]     ram_addr;
  logic              ram_we;
  logic [LANE_W-1:0] ram_wdata;
  logic [LANE_W-1:0] ram_rdata;

  assign req = readEn | writeEn;

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign = |mem_addr[2:0];
`else
  assign misalign = 1'b0;
`endif

  // Full 64-bit compare so huge addresses cannot alias back into range.
  assign acc_err = (readEn & writeEn) | (mem_addr > LAST_START) | misalign;

  assign ram_addr  = addr_q + {{(AW-3){1'b0}}, cnt_q};
  assign ram_we    = (state_q == ST_ACCESS) && !op_rd_q;
  assign ram_wdata = data_q[{cnt_q, 3'b000} +: LANE_W];

  byte_ram #(
    .MEM_BYTES(MEM_BYTES)
  ) u_ram (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_rd_d = op_rd_q;
    err_d   = err_q;
    valm_d  = valm_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d  = mem_addr[AW-1:0];
          data_d  = mem_data;
          op_rd_d = readEn;
          err_d   = acc_err;
          cnt_d   = 3'd0;
          if (acc_err) begin
            state_d = ST_DONE;
            if (readEn) valm_d = 64'd0;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        if (op_rd_q) valm_d[{cnt_q, 3'b000} +: LANE_W] = ram_rdata;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      op_rd_q <= 1'b0;
      err_q   <= 1'b0;
      valm_q  <= 64'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_rd_q <= op_rd_d;
      err_q   <= err_d;
      valm_q  <= valm_d;
    end
  end

  // Address/data latches only matter once a request is accepted.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  assign valM     = valm_q;
  assign dm_error = err_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_data_memory.sv
// Randomized bench for data_memory against a byte-array reference model.
module tb_data_memory;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  localparam int NBYTES = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        readEn = 1'b0;
  logic        writeEn = 1'b0;
  logic [63:0] mem_addr = 64'd0;
  logic [63:0] mem_data = 64'd0;
  logic [63:0] valM;
  logic        dm_error;
  logic        busy;
  logic        done;

  int n_total = 0;
  int n_bad   = 0;

  logic [7:0]  ref_mem [NBYTES];
  logic [63:0] exp_val = 64'd0;
  logic        exp_err = 1'b0;

  always #5 clk = ~clk;

  data_memory #(.MEM_BYTES(NBYTES)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .readEn  (readEn),
    .writeEn (writeEn),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .valM    (valM),
    .dm_error(dm_error),
    .busy    (busy),
    .done    (done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit is_err(input bit rd, input bit wr, input logic [63:0] a);
    return (rd && wr) || (a > 64'(NBYTES - 8)) || (ALIGN && (a[2:0] != 3'd0));
  endfunction

  // One full transaction; optionally pokes writeEn while the access is busy.
  task automatic run_access(input bit rd, input bit wr, input logic [63:0] a,
                            input logic [63:0] d, input bit poke, input string tag);
    int lat;
    int nbusy;
    bit err;
    err = is_err(rd, wr, a);
    @(negedge clk);
    readEn = rd; writeEn = wr; mem_addr = a; mem_data = d;
    @(posedge clk); #1;
    readEn = 1'b0; writeEn = 1'b0;
    mem_addr = $urandom; mem_data = {$urandom, $urandom};
    lat = 99;
    nbusy = 0;
    for (int n = 0; n < 20; n++) begin
      if (busy) nbusy++;
      if (done) begin
        lat = n + 1;
        break;
      end
      if (poke && n == 3) begin
        writeEn = 1'b1; mem_addr = a; mem_data = ~d;
      end else begin
        writeEn = 1'b0;
      end
      @(posedge clk); #1;
    end
    writeEn = 1'b0;
    if (err) begin
      exp_err = 1'b1;
      if (rd) exp_val = 64'd0;
    end else begin
      exp_err = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (rd) exp_val[8*i +: 8] = ref_mem[int'(a[9:0]) + i];
        else    ref_mem[int'(a[9:0]) + i] = d[8*i +: 8];
      end
    end
    check({tag, "_lat"}, 64'(lat), err ? 64'd1 : 64'd9);
    check({tag, "_busy_cycles"}, 64'(nbusy), 64'(lat));
    check({tag, "_valM"}, valM, exp_val);
    check({tag, "_err"}, 64'(dm_error), 64'(exp_err));
    @(posedge clk); #1;
    check({tag, "_idle"}, {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    logic [63:0] a;
    bit rd, wr, poke;
    int kind;

    repeat (2) @(posedge clk);
    #1;
    check("rst_outs", {valM[31:0], 29'd0, dm_error, busy, done}, 64'd0);
    check("rst_valM", valM, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int w = 0; w < NBYTES / 8; w++)
      run_access(1'b0, 1'b1, 64'(w * 8), {$urandom, $urandom}, 1'b0, "fill");

    run_access(1'b0, 1'b1, 64'h100, 64'h0123456789ABCDEF, 1'b0, "rt_wr");
    run_access(1'b1, 1'b0, 64'h100, 64'd0, 1'b0, "rt_rd");
    check("rt_const", valM, 64'h0123456789ABCDEF);

    run_access(1'b0, 1'b1, 64'h108, 64'h1111111111111111, 1'b0, "bo_wr");
    run_access(1'b1, 1'b0, 64'h101, 64'd0, 1'b0, "bo_rd");
    if (!ALIGN) check("bo_const", valM, 64'h110123456789ABCD);

    run_access(1'b1, 1'b0, 64'h3F8, 64'd0, 1'b0, "hi_ok");
    run_access(1'b1, 1'b0, 64'h3F9, 64'd0, 1'b0, "hi_bad");
    check("hi_bad_const", {valM[62:0], dm_error}, 64'd1);
    run_access(1'b1, 1'b0, 64'hFFFFFFFFFFFFFFF8, 64'd0, 1'b0, "wrap_rd");
    run_access(1'b0, 1'b1, 64'hFFFFFFFFFFFFFFF8, 64'hDEAD, 1'b0, "wrap_wr");

    run_access(1'b1, 1'b1, 64'h100, 64'hCAFEF00DCAFEF00D, 1'b0, "conflict");
    run_access(1'b1, 1'b0, 64'h100, 64'd0, 1'b1, "poke_rd");
    run_access(1'b1, 1'b0, 64'h100, 64'd0, 1'b0, "after_poke");
    check("after_poke_const", valM, 64'h0123456789ABCDEF);

    run_access(1'b1, 1'b0, 64'h104, 64'd0, 1'b0, "al_104");
    run_access(1'b1, 1'b0, 64'h105, 64'd0, 1'b0, "al_105");
    check("al_105_err", 64'(dm_error), ALIGN ? 64'd1 : 64'd0);

    // Reset lands on the edge that would write byte 4.
    run_access(1'b0, 1'b1, 64'h200, 64'd0, 1'b0, "mid_clr");
    @(negedge clk);
    writeEn = 1'b1; mem_addr = 64'h200; mem_data = '1;
    @(posedge clk); #1;
    writeEn = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_outs", {valM[60:0], dm_error, busy, done}, 64'd0);
    check("mid_rst_valM", valM, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) ref_mem[16'h200 + i] = 8'hFF;
    exp_val = 64'd0;
    exp_err = 1'b0;
    run_access(1'b1, 1'b0, 64'h200, 64'd0, 1'b0, "mid_rd");
    check("mid_bytes", valM, 64'h00000000FFFFFFFF);

    for (int t = 0; t < 80; t++) begin
      kind = $urandom_range(0, 9);
      rd = $urandom_range(0, 1);
      wr = !rd;
      poke = 1'b0;
      if (kind == 0) begin
        rd = 1'b1; wr = 1'b1;
        a = 64'($urandom_range(0, NBYTES - 8));
      end else if (kind == 1) begin
        a = ($urandom_range(0, 1) != 0) ? {$urandom, $urandom} | 64'h8000_0000_0000_0000
                                        : 64'($urandom_range(NBYTES - 7, NBYTES + 8));
      end else begin
        a = 64'($urandom_range(0, NBYTES - 8));
        poke = rd && ($urandom_range(0, 3) == 0);
      end
      run_access(rd, wr, a, {$urandom, $urandom}, poke, "rand");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
